// File: rtl/eth_frame_rx.sv
// Store-and-forward frame receiver: parses the header, filters on destination, checks the LRC and releases payload only for committed frames.
// Optional build macro ETH_RX_BCAST_EN: treat destination FF:FF:FF:FF:FF:FF as a station match.
module eth_frame_rx #(
  parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
  parameter int          MAX_PAYLOAD   = 64,
  parameter int          FIFO_DEPTH    = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        start,
  output logic        ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);
  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam int          PW         = AW + 1;
  localparam logic [15:0] MAX_LEN    = 16'(MAX_PAYLOAD);
  localparam logic [16:0] FIFO_SPACE = 17'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_MACDST, S_MACSRC, S_LEN, S_PAYLOAD, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    err_code_reg, err_code_next;
  logic [15:0]   cnt_reg, len_reg;
  logic [7:0]    lrc_reg;
  logic          dst_miss_reg;
  logic [PW-1:0] wr_ptr_reg, commit_ptr_reg, rd_ptr_reg;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [7:0]    dest_byte [6];
  logic          filtered, pay_wr, rd_fire;
  logic [15:0]   len_full;
  logic [PW-1:0] used;
  logic [16:0]   free_space;
  logic [7:0]    chk_required;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_dest
      assign dest_byte[gi] = DEST_MAC_ADDR[8*gi +: 8];
    end
  endgenerate

`ifdef ETH_RX_BCAST_EN
  logic bcast_miss_reg;
  assign filtered = dst_miss_reg & bcast_miss_reg;
`else
  assign filtered = dst_miss_reg;
`endif

  assign len_full     = {len_reg[15:8], in_data};
  assign used         = commit_ptr_reg - rd_ptr_reg;
  assign free_space   = FIFO_SPACE - 17'(used);
  assign chk_required = (lrc_reg ^ 8'hFF) + 8'd1;
  assign pay_wr       = (state_reg == S_PAYLOAD) && in_valid && !filtered;
  assign rd_fire      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      err_code_reg <= 3'd0;
    end else begin
      state_reg    <= state_next;
      err_code_reg <= err_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    err_code_next = err_code_reg;
    case (state_reg)
      S_IDLE:     if (start) state_next = S_PREAMBLE;
      S_PREAMBLE: if (in_valid) begin
                    if (in_data != 8'hAA) begin
                      state_next = S_ERR; err_code_next = 3'd1;
                    end else if (cnt_reg == 16'd6) state_next = S_SFD;
                  end
      S_SFD:      if (in_valid) begin
                    if (in_data == 8'hAB) state_next = S_MACDST;
                    else begin state_next = S_ERR; err_code_next = 3'd2; end
                  end
      S_MACDST:   if (in_valid && cnt_reg == 16'd5) state_next = S_MACSRC;
      S_MACSRC:   if (in_valid && cnt_reg == 16'd5) state_next = S_LEN;
      S_LEN:      if (in_valid && cnt_reg == 16'd1) begin
                    if (len_full == 16'd0 || len_full > MAX_LEN) begin
                      state_next = S_ERR; err_code_next = 3'd3;
                    end else if (!filtered && free_space < {1'b0, len_full}) begin
                      state_next = S_ERR; err_code_next = 3'd4;
                    end else state_next = S_PAYLOAD;
                  end
      S_PAYLOAD:  if (in_valid && cnt_reg == len_reg - 16'd1) state_next = S_CHK;
      S_CHK:      if (in_valid) begin
                    if (filtered || in_data == chk_required) state_next = S_DONE;
                    else begin state_next = S_ERR; err_code_next = 3'd5; end
                  end
      S_DONE:     state_next = S_IDLE;
      S_ERR:      state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    err_code  = 3'd0;
    out_valid = (rd_ptr_reg != commit_ptr_reg);
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state_reg)
      S_IDLE:  ready = 1'b1;
      S_DONE:  frame_ok = !filtered;
      S_ERR:   begin frame_err = 1'b1; err_code = err_code_reg; end
      default: ;
    endcase
    // Gate the read so nothing beyond the committed region ever reaches the port.
    if (out_valid) {out_last, out_data} = mem[rd_ptr_reg[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      len_reg        <= '0;
      lrc_reg        <= '0;
      dst_miss_reg   <= 1'b0;
`ifdef ETH_RX_BCAST_EN
      bcast_miss_reg <= 1'b0;
`endif
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
      good_cnt       <= '0;
      drop_cnt       <= '0;
    end else begin
      if (state_next != state_reg) cnt_reg <= '0;
      else if (in_valid)           cnt_reg <= cnt_reg + 16'd1;
      case (state_reg)
        S_IDLE: begin
          lrc_reg        <= '0;
          dst_miss_reg   <= 1'b0;
`ifdef ETH_RX_BCAST_EN
          bcast_miss_reg <= 1'b0;
`endif
        end
        S_MACDST: if (in_valid) begin
          lrc_reg <= lrc_reg + in_data;
          if (in_data != dest_byte[cnt_reg[2:0]]) dst_miss_reg <= 1'b1;
`ifdef ETH_RX_BCAST_EN
          if (in_data != 8'hFF) bcast_miss_reg <= 1'b1;
`endif
        end
        S_MACSRC: if (in_valid) lrc_reg <= lrc_reg + in_data;
        S_LEN: if (in_valid) begin
          lrc_reg <= lrc_reg + in_data;
          if (cnt_reg == 16'd0) len_reg[15:8] <= in_data;
          else                  len_reg[7:0]  <= in_data;
        end
        S_PAYLOAD: if (in_valid) begin
          lrc_reg <= lrc_reg + in_data;
          if (!filtered) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        S_DONE: begin
          if (!filtered) begin
            commit_ptr_reg <= wr_ptr_reg;
            if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
          end else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
        S_ERR: begin
          wr_ptr_reg <= commit_ptr_reg;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
        default: ;
      endcase
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pay_wr) mem[wr_ptr_reg[AW-1:0]] <= {cnt_reg == len_reg - 16'd1, in_data};
  end
endmodule

// File: tb/tb_eth_frame_rx.sv
// Bench for eth_frame_rx: directed frames plus randomized frames scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_eth_frame_rx;
  localparam logic [47:0] DEST  = 48'h00_0a_95_9d_68_16;
  localparam int          MAXP  = 64;
  localparam int          DEPTH = 128;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic        ready, out_last, out_valid, frame_ok, frame_err;
  logic [7:0]  out_data;
  logic [2:0]  err_code;
  logic [15:0] good_cnt, drop_cnt;

  always #5 clk = ~clk;

  eth_frame_rx #(.DEST_MAC_ADDR(DEST), .MAX_PAYLOAD(MAXP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .start(start),
    .ready(ready), .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .good_cnt(good_cnt), .drop_cnt(drop_cnt)
  );

  int         checks = 0, errors = 0;
  int         ok_seen = 0, err_seen = 0;
  logic [2:0] last_err = 3'd0;
  logic [8:0] got_q[$], exp_q[$];
  logic [7:0] frm[$], pay_q[$];
  int         exp_good = 0, exp_drop = 0;
  logic       hold_pend = 1'b0;
  logic [8:0] hold_val = 9'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) hold_pend = 1'b0;
    else begin
      if (hold_pend && out_valid) chk("out_hold", {out_last, out_data}, hold_val);
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_last, out_data};
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (frame_ok) ok_seen++;
      if (frame_err) begin err_seen++; last_err = err_code; end
      if (frame_ok || frame_err) chk("ready_in_pulse", ready, 0);
    end
  end

  // Frame image: 7xAA, AB, dst (byte i = dst[8i+:8]), src, len MSB first, payload, checksum.
  task automatic build(input logic [47:0] dst, input int len, input int chk_delta);
    int sum = 0;
    frm.delete();
    while (pay_q.size() < len) pay_q.push_back(8'($urandom));
    repeat (7) frm.push_back(8'hAA);
    frm.push_back(8'hAB);
    for (int i = 0; i < 6; i++) frm.push_back(dst[8*i +: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
    frm.push_back(8'(len >> 8));
    frm.push_back(8'(len));
    for (int i = 0; i < len; i++) frm.push_back(pay_q[i]);
    for (int i = 8; i < frm.size(); i++) sum += int'(frm[i]);
    frm.push_back(8'(256 - (sum % 256) + chk_delta));
    pay_q.delete();
  endtask

  // Returns 0 for accepted (commit or filtered drop) or the abort cause.
  function automatic int model_code(output bit filt);
    int len, sum, pending;
    bit match;
    logic [7:0] req;
`ifdef ETH_RX_BCAST_EN
    bit bc;
    bc = 1'b1;
`endif
    filt = 1'b0;
    for (int i = 0; i < 7; i++) if (frm[i] != 8'hAA) return 1;
    if (frm[7] != 8'hAB) return 2;
    match = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (frm[8+i] != DEST[8*i +: 8]) match = 1'b0;
`ifdef ETH_RX_BCAST_EN
      if (frm[8+i] != 8'hFF) bc = 1'b0;
`endif
    end
    filt = !match;
`ifdef ETH_RX_BCAST_EN
    if (bc) filt = 1'b0;
`endif
    len = int'({frm[20], frm[21]});
    if (len == 0 || len > MAXP) return 3;
    pending = exp_q.size() - got_q.size();
    if (!filt && (DEPTH - pending) < len) return 4;
    sum = 0;
    for (int i = 8; i < 22 + len; i++) sum += int'(frm[i]);
    req = 8'((256 - (sum % 256)) % 256);
    if (!filt && frm[22+len] != req) return 5;
    return 0;
  endfunction

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin @(negedge clk); t++; end
    chk("idle_wait", ready, 1);
  endtask

  task automatic send(input bit gaps, input bit rnd_rdy, input int n);
    @(posedge clk); #1; start = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin @(posedge clk); #1; start = 1'b0; in_valid = 1'b0; end
      @(posedge clk); #1; start = 1'b0; in_data = frm[i]; in_valid = 1'b1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1; in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic run_frame(input bit gaps, input bit rnd_rdy);
    int code, ok0, err0, len;
    bit filt;
    wait_idle();
    code = model_code(filt);
    len  = int'({frm[20], frm[21]});
    if (code == 0 && !filt) begin
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, frm[22+i]});
      if (exp_good < 65535) exp_good++;
    end else if (exp_drop < 65535) exp_drop++;
    ok0 = ok_seen; err0 = err_seen;
    send(gaps, rnd_rdy, frm.size());
    repeat (3) @(negedge clk);
    chk("ok_pulses", ok_seen - ok0, (code == 0 && !filt) ? 1 : 0);
    chk("err_pulses", err_seen - err0, (code != 0) ? 1 : 0);
    if (code != 0) chk("err_code", last_err, code);
    chk("good_cnt", good_cnt, exp_good);
    chk("drop_cnt", drop_cnt, exp_drop);
    $display("frame len=%0d code=%0d filt=%0d gaps=%0d good=%0d drop=%0d",
             len, code, filt, gaps, good_cnt, drop_cnt);
  endtask

  task automatic drain(output int nlast);
    int t = 0;
    @(posedge clk); #1; out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && t < 500) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("drain_count", got_q.size(), exp_q.size());
    nlast = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("out_byte", got_q[i], exp_q[i]);
    foreach (got_q[i]) if (got_q[i][8]) nlast++;
    $display("drain bytes=%0d last_marks=%0d", got_q.size(), nlast);
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    int nl;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_good_cnt", good_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    build(DEST, 4, 0); run_frame(0, 0); drain(nl);
    chk("good_last_marks", nl, 1);
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    build(DEST, 4, 1); run_frame(0, 0); drain(nl);
    build(DEST, 4, 0); frm[3] = 8'hAB; run_frame(0, 0); drain(nl);
    build(DEST, 0, 0); run_frame(0, 0); drain(nl);
    build(DEST ^ 48'h1, 10, 0); run_frame(0, 0); drain(nl);

    @(posedge clk); #1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin build(DEST, 64, 0); run_frame(0, 0); end
    drain(nl);
    chk("overflow_last_marks", nl, 2);

    build(DEST, 16, 0); run_frame(1, 0); drain(nl);

    @(posedge clk); #1; out_ready = 1'b0;
    build(DEST, 8, 0); run_frame(0, 0);
    build(DEST, 20, 0);
    wait_idle();
    send(0, 0, 27);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_good_cnt", good_cnt, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    got_q.delete(); exp_q.delete(); exp_good = 0; exp_drop = 0;
    @(posedge clk); #1; out_ready = 1'b1;
    build(DEST, 5, 0); run_frame(0, 0); drain(nl);

    for (int f = 0; f < 30; f++) begin
      int sel, len, dlt;
      logic [47:0] dst;
      sel = $urandom_range(0, 5);
      dst = (sel < 3) ? DEST : (sel == 3) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), $urandom};
      if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : MAXP + $urandom_range(1, 4);
      else len = $urandom_range(1, MAXP);
      dlt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
      build(dst, len, dlt);
      if ($urandom_range(0, 9) == 0) frm[$urandom_range(0, 6)] = 8'hAA ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) frm[7] = 8'h55;
      run_frame(1'($urandom_range(0, 1)), 1'b1);
      drain(nl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/eth_frame_rx.md
# eth_frame_rx

Parametrised, store-and-forward Ethernet-style frame receiver. Parses preamble, SFD, destination/source MAC, 16-bit length, payload and one-byte LRC checksum from a byte stream qualified by `in_valid`. It filters frames on destination address and buffers payload in an internal FIFO. Payload is released on a valid/ready stream only after the checksum passes; bad frames are rolled back and never appear on the output. It sits between the PHY byte interface and downstream packet consumers, and reports status pulses and statistics counters.

## Interface
- `DEST_MAC_ADDR`, default 48'h00_0a_95_9d_68_16; station address. Byte i of the destination field is compared to `DEST_MAC_ADDR[8*i +: 8]`.
- `MAX_PAYLOAD`, default 64; largest legal length field value, in bytes.
- `FIFO_DEPTH`, default 128; payload buffer entries. Must be a power of two and ≥ `MAX_PAYLOAD`.
- `clk` in 1: clock.
- `rst` in 1: reset; rst, synchronous, active-high; clock clk.
- `in_data` in 8: received byte.
- `in_valid` in 1: `in_data` valid this cycle. Cycles with `in_valid` low are ignored in every state.
- `start` in 1: frame start. Sampled only in IDLE.
- `ready` out 1: high only in IDLE.
- `out_data` out 8: payload byte.
- `out_last` out 1: marks the final payload byte of a frame.
- `out_valid` out 1: `out_data`/`out_last` valid.
- `out_ready` in 1: consumer accepts the byte.
- `frame_ok` out 1: one-cycle pulse when a frame is committed.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `err_code` out 3: cause, valid with `frame_err`. 1 preamble, 2 SFD, 3 length, 4 overflow, 5 checksum; 0 otherwise.
- `good_cnt` out 16: committed frames, saturating.
- `drop_cnt` out 16: aborted plus address-filtered frames, saturating.

## Operation
- States: IDLE, PREAMBLE, SFD, MACDST, MACSRC, LEN, PAYLOAD, CHK, DONE, ERR. Each data state consumes only `in_valid` bytes, using a 16-bit byte counter cleared on every state change.
- IDLE: `start`=1 → PREAMBLE.
- PREAMBLE: 7 bytes, each must equal 8'hAA, else ERR(1).
- SFD: 1 byte, must equal 8'hAB, else ERR(2).
- MACDST: 6 bytes. On any mismatch, the frame is marked filtered and parsing continues.
- MACSRC: 6 bytes, content ignored.
- LEN: 2 bytes, MSB first.
  - Length 0 or > `MAX_PAYLOAD` → ERR(3). This check applies to filtered frames too.
  - Unfiltered frame with free space < length → ERR(4). Free space = `FIFO_DEPTH` − (commit_ptr − rd_ptr).
- PAYLOAD: exactly length bytes.
  - Unfiltered frame: each byte is written at wr_ptr with a last bit. The last bit is set on the final byte.
  - Filtered frame: nothing is written.
- CHK: 1 byte.
  - LRC = 8-bit modular sum of all MACDST, MACSRC, LEN and PAYLOAD bytes. Required checksum = (LRC ^ 8'hFF) + 1.
  - Mismatch on an unfiltered frame → ERR(5).
  - Match, or any filtered frame → DONE.
- DONE (1 cycle):
  - Unfiltered: commit_ptr ← wr_ptr, `frame_ok`=1, `good_cnt`++.
  - Filtered: `drop_cnt`++ only, no pulse.
  - Next state IDLE.
- ERR (1 cycle): wr_ptr ← commit_ptr (rollback), `frame_err`=1, `err_code` set, `drop_cnt`++. Next state IDLE.
- Output stream:
  - `out_valid` = (rd_ptr ≠ commit_ptr).
  - `out_data`/`out_last` are the entry at rd_ptr.
  - rd_ptr advances on `out_valid && out_ready`.
  - Uncommitted bytes are never visible.
- Pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally.
- A FIFO write and an output read in the same cycle are both performed.
- A read in the DONE or ERR cycle uses the pre-update commit_ptr.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - state IDLE, all pointers 0, LRC 0, counters 0.
  - `ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0.
- Reset mid-frame or mid-drain empties the FIFO, including committed but unread data.
- `frame_ok`/`frame_err` assert in the cycle after the CHK (or failing) byte is accepted. `ready` is low in that cycle.
- The earliest `out_valid` is 1 cycle after `frame_ok`.
- Throughput is 1 byte/cycle into and out of the FIFO.
- `start` outside IDLE is ignored. `start` in the DONE/ERR cycle is lost.
- `out_data` is held stable while `out_valid && !out_ready`.

## Configuration
- `ETH_RX_BCAST_EN`:
  - Defined: a destination of 48'hFF_FF_FF_FF_FF_FF is accepted as if it matched `DEST_MAC_ADDR`.
  - Undefined: broadcast frames are filtered like any other mismatch.

## Test plan
- Good frame to `DEST_MAC_ADDR` with length 4, payload 01 02 03 04 and correct checksum, `out_ready`=1 → `frame_ok`, then 4 bytes out with `out_last` on 04, `good_cnt`=1.
- Same frame with checksum+1 → `frame_err`, `err_code`=5, no `out_valid`, `drop_cnt`=1, wr_ptr equals commit_ptr.
- Preamble byte 3 = 8'hAB → ERR with `err_code`=1. Length field 0 → `err_code`=3.
- Destination mismatch, length 10 → no pulse, no output, `drop_cnt`=1, `ready` high after CHK+1.
- `FIFO_DEPTH`=128, `out_ready`=0, two 64-byte good frames followed by a third → third gives `err_code`=4. Raising `out_ready` drains 128 bytes in order with 2 `out_last`.
- `in_valid` toggling every other cycle during a good frame → identical result to the gap-free case. Reset during PAYLOAD → IDLE, FIFO empty, counters 0.
